// File: rtl/data_mem_be.sv
// data_mem_be: byte-addressed big-endian data memory for the MIPS32 MEM stage.
// Supports byte/half/word loads and stores with sign or zero extension, a
// configurable wait-state counter and error reporting for misaligned or
// out-of-range accesses. Optional feature macro: DATA_MEM_PARITY_EN adds one
// even-parity bit per byte lane, which is checked on loads.
//
// Handshake: a request is taken on a rising edge where ready=1, req=1 and
// (read_wire | write_wire)=1. All request fields are latched on that edge and
// may change afterwards. ready stays 0 until the edge that leaves DONE. done
// is a single-cycle pulse, and the error flags are meaningful only with done.
// Requests made while ready=0 are ignored, not queued.
module data_mem_be #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               read_wire,
  input  logic               write_wire,
  input  logic [31:0]        address,
  input  logic [1:0]         size,
  input  logic               unsigned_ld,
  input  logic signed [31:0] write_data,
  output logic signed [31:0] read_data,
  output logic               ready,
  output logic               done,
  output logic               misalign,
  output logic               out_of_range,
  output logic               parity_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;

  // Request fields captured at acceptance
  logic          is_load_q;
  logic [1:0]    size_q;
  logic [1:0]    off_q;
  logic [AW-1:0] idx_q;
  logic          uns_q;
  logic [31:0]   wdata_q;
  logic          mis_q;
  logic          oor_q;
  logic [31:0]   rdata_q;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          accept;
  logic          mis_in;
  logic          oor_in;
  logic          perform;
  logic [3:0]    lane_en;
  logic [31:0]   wr_lanes;
  logic [31:0]   word_rd;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ld_val;

  assign accept  = (state_q == IDLE) && req && (read_wire || write_wire);
  assign mis_in  = ((size == 2'b01) && address[0]) ||
                   ((size == 2'b10) && (address[1:0] != 2'b00)) ||
                   (size == 2'b11);
  assign oor_in  = {2'b00, address[31:2]} >= 32'(DEPTH_WORDS);
  // The array is touched only on the last wait edge of an error-free access
  assign perform = (state_q == WAIT) && (cnt_q == 4'd0) && !mis_q && !oor_q;
  assign word_rd = mem_q[idx_q];

  // Byte lanes selected by the access; bit 3 is the MSB lane (offset 0)
  always_comb begin
    lane_en = 4'b0000;
    case (size_q)
      2'b00:   lane_en = 4'b1000 >> off_q;
      2'b01:   lane_en = off_q[1] ? 4'b0011 : 4'b1100;
      2'b10:   lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  // Store data replicated so every candidate lane carries the low bits
  always_comb begin
    wr_lanes = wdata_q;
    case (size_q)
      2'b00:   wr_lanes = {4{wdata_q[7:0]}};
      2'b01:   wr_lanes = {2{wdata_q[15:0]}};
      default: wr_lanes = wdata_q;
    endcase
  end

  // Load path: pick the addressed lane, right-justify and extend
  always_comb begin
    byte_sel = word_rd[31:24];
    case (off_q)
      2'd0:    byte_sel = word_rd[31:24];
      2'd1:    byte_sel = word_rd[23:16];
      2'd2:    byte_sel = word_rd[15:8];
      default: byte_sel = word_rd[7:0];
    endcase
    half_sel = off_q[1] ? word_rd[15:0] : word_rd[31:16];
    case (size_q)
      2'b00:   ld_val = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   ld_val = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ld_val = word_rd;
    endcase
  end

`ifdef DATA_MEM_PARITY_EN
  logic [3:0] par_q [DEPTH_WORDS];
  logic [3:0] par_new;
  logic [3:0] par_chk;
  logic       perr_calc;
  logic       perr_q;

  // Even parity per lane for the write, and recomputed parity for the read
  always_comb begin
    par_new = 4'b0000;
    par_chk = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      par_new[i] = ^wr_lanes[8*i +: 8];
      par_chk[i] = ^word_rd[8*i +: 8];
    end
    perr_calc = |(lane_en & (par_chk ^ par_q[idx_q]));
  end

  // Parity bits follow the data lanes written
  always_ff @(posedge clk) begin
    if (perform && !is_load_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) par_q[idx_q][i] <= par_new[i];
      end
    end
  end

  // Parity result is captured with the load and cleared on each new request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else if (accept) begin
      perr_q <= 1'b0;
    end else if (perform && is_load_q) begin
      perr_q <= perr_calc;
    end
  end

  assign parity_err = (state_q == DONE) && perr_q;
`else
  assign parity_err = 1'b0;
`endif

  // Array write: no reset, contents are undefined until stored
  always_ff @(posedge clk) begin
    if (perform && !is_load_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem_q[idx_q][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  // Next-state logic; error requests skip the wait states and the access
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = (mis_in || oor_in) ? 4'd0 : WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and wait counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture at acceptance and load result update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_load_q <= 1'b0;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
      idx_q     <= '0;
      uns_q     <= 1'b0;
      wdata_q   <= 32'h0;
      mis_q     <= 1'b0;
      oor_q     <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      if (accept) begin
        is_load_q <= read_wire;
        size_q    <= size;
        off_q     <= address[1:0];
        idx_q     <= address[AW+1:2];
        uns_q     <= unsigned_ld;
        wdata_q   <= write_data;
        mis_q     <= mis_in;
        oor_q     <= oor_in;
      end
      if (perform && is_load_q) rdata_q <= ld_val;
    end
  end

  assign read_data    = rdata_q;
  assign ready        = (state_q == IDLE);
  assign done         = (state_q == DONE);
  assign misalign     = (state_q == DONE) && mis_q;
  assign out_of_range = (state_q == DONE) && oor_q;

endmodule

// File: tb/tb_data_mem_be.sv
// Bench for data_mem_be: two instances (0 and 3 wait states) share the
// request fields; each has its own req. A byte-level big-endian model and an
// expected-result queue provide every expected value.
module tb_data_mem_be;

  localparam int W0 = 0;
  localparam int W1 = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic        read_wire, write_wire, unsigned_ld;
  logic [31:0] address, write_data;
  logic [1:0]  size;

  logic [31:0] rd0, rd1;
  logic        ready0, ready1, done0, done1;
  logic        mis0, mis1, oor0, oor1, perr0, perr1;

  logic        sel = 1'b0;
  logic [31:0] o_rd;
  logic        o_ready, o_done, o_mis, o_oor, o_perr;

  int          n_run  = 0;
  int          n_fail = 0;
  logic [34:0] exp_q[$];
  logic [31:0] last_rd [2];
  logic [7:0]  bmem [int];

  always #5 clk = ~clk;

  data_mem_be #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .read_wire(read_wire),
    .write_wire(write_wire), .address(address), .size(size),
    .unsigned_ld(unsigned_ld), .write_data(write_data), .read_data(rd0),
    .ready(ready0), .done(done0), .misalign(mis0), .out_of_range(oor0),
    .parity_err(perr0)
  );

  data_mem_be #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .read_wire(read_wire),
    .write_wire(write_wire), .address(address), .size(size),
    .unsigned_ld(unsigned_ld), .write_data(write_data), .read_data(rd1),
    .ready(ready1), .done(done1), .misalign(mis1), .out_of_range(oor1),
    .parity_err(perr1)
  );

  assign o_rd    = sel ? rd1    : rd0;
  assign o_ready = sel ? ready1 : ready0;
  assign o_done  = sel ? done1  : done0;
  assign o_mis   = sel ? mis1   : mis0;
  assign o_oor   = sel ? oor1   : oor0;
  assign o_perr  = sel ? perr1  : perr0;

  function automatic int key(input logic s, input logic [31:0] a);
    return (s ? 65536 : 0) + int'(a[15:0]);
  endfunction

  function automatic void mdl_store(input logic s, input logic [31:0] a,
                                    input logic [1:0] sz, input logic [31:0] wd);
    int k = key(s, a);
    case (sz)
      2'b00: bmem[k] = wd[7:0];
      2'b01: begin bmem[k] = wd[15:8]; bmem[k+1] = wd[7:0]; end
      default: for (int j = 0; j < 4; j++) bmem[k+j] = wd[31-8*j -: 8];
    endcase
  endfunction

  function automatic logic [31:0] mdl_load(input logic s, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
    int k = key(s, a);
    logic [7:0]  b;
    logic [15:0] h;
    case (sz)
      2'b00: begin b = bmem[k]; return uns ? {24'h0, b} : {{24{b[7]}}, b}; end
      2'b01: begin h = {bmem[k], bmem[k+1]};
                   return uns ? {16'h0, h} : {{16{h[15]}}, h}; end
      default: return {bmem[k], bmem[k+1], bmem[k+2], bmem[k+3]};
    endcase
  endfunction

  // One request on instance s, waiting (bounded) for done and checking it.
  // poke raises a conflicting store request while the instance is busy.
  task automatic do_access(input logic s, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [1:0] sz,
                           input logic uns, input logic [31:0] wd,
                           input logic [31:0] exp_ld, input logic exp_mis,
                           input logic exp_oor, input logic exp_par,
                           input logic poke, input string name);
    int          lat_exp, n;
    logic        err;
    logic [34:0] exp_v, got_v;
    err = exp_mis | exp_oor;
    lat_exp = err ? 1 : (s ? W1 + 1 : W0 + 1);
    if (!err && rd) last_rd[s] = exp_ld;
    exp_q.push_back({exp_mis, exp_oor, exp_par, last_rd[s]});
    if (!err && !rd && wr) mdl_store(s, a, sz, wd);
    sel = s; read_wire = rd; write_wire = wr; address = a; size = sz;
    unsigned_ld = uns; write_data = wd;
    if (s) req1 = 1'b1; else req0 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    n_run++;
    if (o_ready !== 1'b0 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy: ready=%b done=%b, required ready=0 done=0",
               name, o_ready, o_done);
    end
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (o_done) break;
      if (poke && n == 1) begin
        read_wire = 1'b0; write_wire = 1'b1; address = 32'h20; size = 2'b10;
        write_data = 32'h12345678; req1 = 1'b1;
      end
      if (poke && n == 2) req1 = 1'b0;
    end
    exp_v = exp_q.pop_front();
    n_run++;
    if (n !== lat_exp) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges, required %0d", name, n, lat_exp);
    end
    got_v = {o_mis, o_oor, o_perr, o_rd};
    n_run++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s result: mis/oor/par/rd got %b%b%b %h, required %b%b%b %h",
               name, got_v[34], got_v[33], got_v[32], got_v[31:0],
               exp_v[34], exp_v[33], exp_v[32], exp_v[31:0]);
    end
    @(negedge clk);
    n_run++;
    if (o_done !== 1'b0 || o_ready !== 1'b1 || o_mis !== 1'b0 || o_oor !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after: done=%b ready=%b mis=%b oor=%b, required 0 1 0 0",
               name, o_done, o_ready, o_mis, o_oor);
    end
  endtask

  task automatic test_reset();
    logic [36:0] got;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; read_wire = 1'b0; write_wire = 1'b0;
    address = 32'h0; size = 2'b00; unsigned_ld = 1'b0; write_data = 32'h0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      got = {o_rd, o_ready, o_done, o_mis, o_oor, o_perr};
      n_run++;
      if (got !== {32'h0, 5'b10000}) begin
        n_fail++;
        $display("FAIL reset_%0d: rd/rdy/done/mis/oor/par got %h %b, required 0 10000",
                 s, got[36:5], got[4:0]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_rw();
    do_access(0, 0, 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0, "st_word");
    do_access(0, 1, 0, 32'h10, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0, "ld_word");
  endtask

  task automatic test_lanes();
    do_access(0, 0, 1, 32'h11, 2'b00, 0, 32'hAAAAAA55, 32'h0, 0, 0, 0, 0, "st_byte");
    do_access(0, 1, 0, 32'h10, 2'b10, 0, 32'h0, 32'hDE55BEEF, 0, 0, 0, 0, "ld_after_byte");
    do_access(0, 1, 0, 32'h10, 2'b00, 0, 32'h0, 32'hFFFFFFDE, 0, 0, 0, 0, "ld_sbyte0");
    do_access(0, 1, 0, 32'h12, 2'b01, 1, 32'h0, 32'h0000BEEF, 0, 0, 0, 0, "ld_uhalf2");
    do_access(0, 1, 0, 32'h12, 2'b01, 0, 32'h0, 32'hFFFFBEEF, 0, 0, 0, 0, "ld_shalf2");
    do_access(0, 1, 0, 32'h11, 2'b00, 1, 32'h0, 32'h00000055, 0, 0, 0, 0, "ld_ubyte1");
    do_access(0, 1, 0, 32'h13, 2'b00, 0, 32'h0, 32'hFFFFFFEF, 0, 0, 0, 0, "ld_sbyte3");
    do_access(0, 0, 1, 32'h12, 2'b01, 0, 32'hFFFF1234, 32'h0, 0, 0, 0, 0, "st_half2");
    do_access(0, 1, 0, 32'h10, 2'b10, 0, 32'h0, 32'hDE551234, 0, 0, 0, 0, "ld_after_half2");
    do_access(0, 0, 1, 32'h10, 2'b01, 0, 32'h00008001, 32'h0, 0, 0, 0, 0, "st_half0");
    do_access(0, 1, 0, 32'h10, 2'b10, 0, 32'h0, 32'h80011234, 0, 0, 0, 0, "ld_after_half0");
    do_access(0, 1, 0, 32'h10, 2'b01, 0, 32'h0, 32'hFFFF8001, 0, 0, 0, 0, "ld_shalf0");
  endtask

  task automatic test_errors();
    do_access(0, 0, 1, 32'h0, 2'b10, 0, 32'h01020304, 32'h0, 0, 0, 0, 0, "st_word0");
    do_access(0, 1, 0, 32'h13, 2'b10, 0, 32'h0, 32'h0, 1, 0, 0, 0, "ld_word_mis");
    do_access(0, 0, 1, 32'h4000, 2'b01, 0, 32'hFFFFFFFF, 32'h0, 0, 1, 0, 0, "st_half_oor");
    do_access(0, 1, 0, 32'h11, 2'b01, 0, 32'h0, 32'h0, 1, 0, 0, 0, "ld_half_mis");
    do_access(0, 1, 0, 32'h10, 2'b11, 0, 32'h0, 32'h0, 1, 0, 0, 0, "ld_size3");
    do_access(0, 1, 0, 32'h4002, 2'b10, 0, 32'h0, 32'h0, 1, 1, 0, 0, "ld_both_err");
    do_access(0, 0, 1, 32'h11, 2'b10, 0, 32'h0, 32'h0, 1, 0, 0, 0, "st_word_mis");
    do_access(0, 1, 0, 32'h10, 2'b10, 0, 32'h0, 32'h80011234, 0, 0, 0, 0, "ld_10_intact");
    do_access(0, 1, 0, 32'h0, 2'b10, 0, 32'h0, 32'h01020304, 0, 0, 0, 0, "ld_0_intact");
  endtask

  task automatic test_ignored_req();
    sel = 1'b0; read_wire = 1'b0; write_wire = 1'b0; req0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_run++;
      if (o_ready !== 1'b1 || o_done !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_req_%0d: ready=%b done=%b, required 1 0", i, o_ready, o_done);
      end
    end
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wait_states();
    do_access(1, 0, 1, 32'h10, 2'b10, 0, 32'hCAFEF00D, 32'h0, 0, 0, 0, 0, "w3_st10");
    do_access(1, 0, 1, 32'h20, 2'b10, 0, 32'h0BADC0DE, 32'h0, 0, 0, 0, 0, "w3_st20");
    do_access(1, 1, 0, 32'h10, 2'b10, 0, 32'h0, 32'hCAFEF00D, 0, 0, 0, 1, "w3_ld_busy");
    do_access(1, 1, 0, 32'h20, 2'b10, 0, 32'h0, 32'h0BADC0DE, 0, 0, 0, 0, "w3_ld20");
    do_access(1, 1, 0, 32'h23, 2'b00, 1, 32'h0, 32'h000000DE, 0, 0, 0, 0, "w3_ubyte");
    do_access(1, 1, 0, 32'h13, 2'b10, 0, 32'h0, 32'h0, 1, 0, 0, 0, "w3_mis");
  endtask

  task automatic test_rd_wr_both();
    do_access(1, 1, 1, 32'h10, 2'b10, 0, 32'hFFFFFFFF, 32'hCAFEF00D, 0, 0, 0, 0, "rdwr_ld");
    do_access(1, 1, 0, 32'h10, 2'b10, 0, 32'h0, 32'hCAFEF00D, 0, 0, 0, 0, "rdwr_intact");
  endtask

  task automatic test_reset_mid();
    logic [36:0] got;
    sel = 1'b1; read_wire = 1'b0; write_wire = 1'b1; address = 32'h10;
    size = 2'b10; write_data = 32'h11111111; req1 = 1'b1;
    @(posedge clk);
    #1;
    req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      got = {o_rd, o_ready, o_done, o_mis, o_oor, o_perr};
      n_run++;
      if (got !== {32'h0, 5'b10000}) begin
        n_fail++;
        $display("FAIL mid_reset_%0d: rd/rdy/done/mis/oor/par got %h %b, required 0 10000",
                 s, got[36:5], got[4:0]);
      end
    end
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_run++;
      if (done0 !== 1'b0 || done1 !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_done_%0d: done0=%b done1=%b, required 0 0", i, done0, done1);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_run++;
    if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_ready: ready0=%b ready1=%b, required 1 1", ready0, ready1);
    end
    do_access(1, 1, 0, 32'h10, 2'b10, 0, 32'h0, 32'hCAFEF00D, 0, 0, 0, 0, "mid_reset_intact");
  endtask

  task automatic test_random();
    logic [31:0] a, wd, e;
    logic [1:0]  sz;
    logic        ld, uns, mis;
    for (int i = 0; i < 16; i++)
      do_access(0, 0, 1, 32'(4 * i), 2'b10, 0, $urandom, 32'h0, 0, 0, 0, 0, "rnd_init");
    for (int i = 0; i < 40; i++) begin
      a   = 32'($urandom_range(0, 63));
      sz  = 2'($urandom_range(0, 3));
      ld  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wd  = $urandom;
      mis = (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || (sz == 2'b11);
      e   = (ld && !mis) ? mdl_load(0, a, sz, uns) : 32'h0;
      do_access(0, ld, !ld, a, sz, uns, wd, e, mis, 0, 0, 0, "rnd_op");
    end
  endtask

`ifdef DATA_MEM_PARITY_EN
  task automatic test_parity();
    do_access(0, 0, 1, 32'h40, 2'b10, 0, 32'hA5A5A5A5, 32'h0, 0, 0, 0, 0, "par_st40");
    do_access(0, 0, 1, 32'h44, 2'b10, 0, 32'h00FF00FF, 32'h0, 0, 0, 0, 0, "par_st44");
    u_dut0.mem_q[16][3] = ~u_dut0.mem_q[16][3];
    bmem[key(0, 32'h43)] = bmem[key(0, 32'h43)] ^ 8'h08;
    do_access(0, 1, 0, 32'h40, 2'b10, 0, 32'h0, 32'hA5A5A5AD, 0, 0, 1, 0, "par_ld_flip");
    do_access(0, 1, 0, 32'h40, 2'b00, 0, 32'h0, 32'hFFFFFFA5, 0, 0, 0, 0, "par_ld_clean_lane");
    do_access(0, 1, 0, 32'h43, 2'b00, 1, 32'h0, 32'h000000AD, 0, 0, 1, 0, "par_ld_flip_lane");
    do_access(0, 1, 0, 32'h44, 2'b10, 0, 32'h0, 32'h00FF00FF, 0, 0, 0, 0, "par_ld_clean");
  endtask
`endif

  initial begin
    test_reset();
    test_word_rw();
    test_lanes();
    test_errors();
    test_ignored_req();
    test_wait_states();
    test_rd_wr_both();
    test_reset_mid();
    test_random();
`ifdef DATA_MEM_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
